// File: rtl/spi_rx_pkg.sv
// Shared constants and types for the SPI slave receiver: register map,
// STATUS/CTRL bit positions, AHB transfer encodings and the receiver state type.
package spi_rx_pkg;

   localparam logic [3:0] ADDR_DATA   = 4'h0;
   localparam logic [3:0] ADDR_STATUS = 4'h4;
   localparam logic [3:0] ADDR_CTRL   = 4'h8;
   localparam logic [3:0] ADDR_CLR    = 4'hC;

   localparam int STAT_NOT_EMPTY = 0;
   localparam int STAT_FULL      = 1;
   localparam int STAT_OVR       = 2;
   localparam int STAT_CNT_LSB   = 4;

   localparam int CTRL_EN        = 0;
   localparam int CTRL_LSB_FIRST = 1;
   localparam int CLR_OVR        = 2;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } rx_state_t;

endpackage

// File: rtl/spi_rx_fifo.sv
// Synchronous byte FIFO with registered pointers and occupancy count.
// A pop while full frees the slot that a simultaneous push then takes.
module spi_rx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             empty,
   output logic             full
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rdata   = mem[rd_ptr];

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage is not reset; occupancy is tracked by count, so stale entries are never observed.
   always_ff @(posedge CLK) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/spi_rx.sv
// SPI mode-0 slave receiver: synchronizes SCLK/SS/MOSI into CLK, assembles
// bytes into a receive FIFO and exposes DATA/STATUS/CTRL/CLR over AHB-Lite.
module spi_rx
   import spi_rx_pkg::*;
#(
   parameter int FIFO_DEPTH    = 4,
   parameter bit LSB_FIRST_DEF = 1'b1
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        HSEL,
   input  logic [1:0]  HTRANS,
   input  logic [3:0]  HADDR,
   input  logic        HWRITE,
   input  logic        HREADY,
   output logic        HREADY_RESP,
   input  logic [31:0] HWDATA,
   output logic [31:0] HRDATA,
   input  logic        SCLK,
   input  logic        SS,
   input  logic        MOSI
);

   logic [2:0] sclk_sync;
   logic [1:0] ss_sync;
   logic [1:0] mosi_sync;
   logic [1:0] sync_live;
   logic       armed;
   logic       ss_s;
   logic       mosi_s;
   logic       sclk_rise;

   logic       ctrl_en;
   logic       ctrl_lsb;
   logic       ovr;

   logic       dp_valid;
   logic       dp_write;
   logic [3:0] dp_addr;
   logic       addr_phase;
   logic       rd_phase;
   logic       wr_phase;
   logic       fifo_pop;

   rx_state_t  state;
   logic [2:0] bit_cnt;
   logic [7:0] shreg;
   logic       lsb_lat;
   logic       push_q;

   logic [7:0] fifo_rdata;
   logic       fifo_empty;
   logic       fifo_full;
   logic       overflow;

   logic       unused_ok;

   assign HREADY_RESP = 1'b1;
   assign unused_ok   = ^{HWDATA[31:3], HTRANS[0]};

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sclk_sync <= 3'b000;
         ss_sync   <= 2'b11;
         mosi_sync <= 2'b00;
      end else begin
         sclk_sync <= {sclk_sync[1:0], SCLK};
         ss_sync   <= {ss_sync[0], SS};
         mosi_sync <= {mosi_sync[0], MOSI};
      end
   end

   assign ss_s      = ss_sync[1];
   assign mosi_s    = mosi_sync[1];
   assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];

   // SS must be seen high once the synchronizer holds real pin samples, so a
   // frame interrupted by reset is not resumed halfway through.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sync_live <= 2'b00;
         armed     <= 1'b0;
      end else begin
         sync_live <= {sync_live[0], 1'b1};
         if (sync_live[1] && ss_s) armed <= 1'b1;
      end
   end

   assign addr_phase = HSEL & HTRANS[1] & HREADY;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         dp_valid <= 1'b0;
         dp_write <= 1'b0;
         dp_addr  <= '0;
      end else begin
         dp_valid <= addr_phase;
         if (addr_phase) begin
            dp_write <= HWRITE;
            dp_addr  <= HADDR;
         end
      end
   end

   assign rd_phase = dp_valid & ~dp_write;
   assign wr_phase = dp_valid & dp_write;
   assign fifo_pop = rd_phase & (dp_addr == ADDR_DATA);
   assign overflow = push_q & fifo_full & ~fifo_pop;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         ctrl_en  <= 1'b0;
         ctrl_lsb <= LSB_FIRST_DEF;
         ovr      <= 1'b0;
      end else begin
         if (wr_phase && dp_addr == ADDR_CTRL) begin
            ctrl_en  <= HWDATA[CTRL_EN];
            ctrl_lsb <= HWDATA[CTRL_LSB_FIRST];
         end
         if (overflow)
            ovr <= 1'b1;
         else if (wr_phase && dp_addr == ADDR_CLR && HWDATA[CLR_OVR])
            ovr <= 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state   <= ST_IDLE;
         bit_cnt <= '0;
         shreg   <= '0;
         lsb_lat <= LSB_FIRST_DEF;
         push_q  <= 1'b0;
      end else begin
         push_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (ctrl_en && !ss_s && armed) begin
                  state   <= ST_SHIFT;
                  bit_cnt <= '0;
                  lsb_lat <= ctrl_lsb;
               end
            end
            ST_SHIFT: begin
               if (ss_s || !ctrl_en) begin
                  state <= ST_IDLE;
               end else if (sclk_rise) begin
                  shreg   <= lsb_lat ? {mosi_s, shreg[7:1]} : {shreg[6:0], mosi_s};
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == 3'd7) push_q <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // shreg stays stable for the push cycle: the next SCLK edge is several CLKs away.
   spi_rx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .CLK   (CLK),
      .RST_N (RST_N),
      .push  (push_q),
      .pop   (fifo_pop),
      .wdata (shreg),
      .rdata (fifo_rdata),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   // NOTE: every output of this block gets a default first, so no latch is inferred.
   always_comb begin
      HRDATA = '0;
      if (rd_phase) begin
         case (dp_addr)
            ADDR_DATA: begin
               if (!fifo_empty) HRDATA[7:0] = fifo_rdata;
            end
            ADDR_STATUS: begin
               HRDATA[STAT_NOT_EMPTY]        = ~fifo_empty;
               HRDATA[STAT_FULL]             = fifo_full;
               HRDATA[STAT_OVR]              = ovr;
               HRDATA[STAT_CNT_LSB +: 3]     = bit_cnt;
            end
            ADDR_CTRL: begin
               HRDATA[CTRL_EN]        = ctrl_en;
               HRDATA[CTRL_LSB_FIRST] = ctrl_lsb;
            end
            default: HRDATA = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_rx.sv
// Directed plus randomized bench for spi_rx; expected bytes and STATUS come
// from a queue model of the receive FIFO and its sticky overrun flag.
`timescale 1ns/1ps
module tb_spi_rx;

   localparam int DEPTH = 4;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        HSEL = 1'b0;
   logic [1:0]  HTRANS = 2'b00;
   logic [3:0]  HADDR = 4'h0;
   logic        HWRITE = 1'b0;
   logic        HREADY = 1'b1;
   logic        HREADY_RESP;
   logic [31:0] HWDATA = '0;
   logic [31:0] HRDATA;
   logic        SCLK = 1'b0;
   logic        SS = 1'b1;
   logic        MOSI = 1'b0;

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_q[$];
   logic       exp_ovr = 1'b0;

   spi_rx #(.FIFO_DEPTH(DEPTH), .LSB_FIRST_DEF(1'b1)) dut (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .HSEL        (HSEL),
      .HTRANS      (HTRANS),
      .HADDR       (HADDR),
      .HWRITE      (HWRITE),
      .HREADY      (HREADY),
      .HREADY_RESP (HREADY_RESP),
      .HWDATA      (HWDATA),
      .HRDATA      (HRDATA),
      .SCLK        (SCLK),
      .SS          (SS),
      .MOSI        (MOSI)
   );

   always #5 CLK = ~CLK;

   initial begin
      #500us;
      $display("FAIL watchdog: observed no finish, required finish within 500us");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic ahb_write(input logic [3:0] addr, input logic [31:0] data);
      @(negedge CLK);
      HSEL = 1'b1; HTRANS = 2'b10; HADDR = addr; HWRITE = 1'b1;
      @(negedge CLK);
      HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = data;
   endtask

   task automatic ahb_read(input logic [3:0] addr, output logic [31:0] data);
      @(negedge CLK);
      HSEL = 1'b1; HTRANS = 2'b10; HADDR = addr; HWRITE = 1'b0;
      @(negedge CLK);
      HSEL = 1'b0; HTRANS = 2'b00;
      #1 data = HRDATA;
   endtask

   function automatic logic [31:0] exp_status(input int cnt);
      logic [31:0] s;
      s = 32'(cnt) << 4;
      if (exp_ovr)                s[2] = 1'b1;
      if (exp_q.size() == DEPTH)  s[1] = 1'b1;
      if (exp_q.size() != 0)      s[0] = 1'b1;
      return s;
   endfunction

   function automatic void model_push(input logic [7:0] b);
      if (exp_q.size() == DEPTH) exp_ovr = 1'b1;
      else exp_q.push_back(b);
   endfunction

   task automatic check_status(input string tag, input int cnt);
      logic [31:0] d;
      ahb_read(4'h4, d);
      check(tag, d, exp_status(cnt));
   endtask

   task automatic check_data(input string tag);
      logic [31:0] d;
      logic [31:0] e;
      ahb_read(4'h0, d);
      e = (exp_q.size() != 0) ? {24'h0, exp_q.pop_front()} : 32'h0;
      check(tag, d, e);
   endtask

   task automatic spi_bit(input logic b);
      @(negedge CLK); MOSI = b;
      repeat (4) @(negedge CLK);
      SCLK = 1'b1;
      repeat (4) @(negedge CLK);
      SCLK = 1'b0;
   endtask

   task automatic send_bits(input logic [7:0] b, input logic lsb, input int nbits);
      for (int i = 0; i < nbits; i++) spi_bit(lsb ? b[i] : b[7-i]);
      if (nbits == 8) model_push(b);
      repeat (4) @(negedge CLK);
   endtask

   task automatic ss_low();
      @(negedge CLK); SS = 1'b0;
      repeat (4) @(negedge CLK);
   endtask

   task automatic ss_high();
      repeat (2) @(negedge CLK); SS = 1'b1;
      repeat (4) @(negedge CLK);
   endtask

   initial begin
      logic [31:0] d;
      logic [7:0]  nb;
      logic        lsb;
      int          n;

      // Reset state.
      repeat (3) @(negedge CLK);
      check("rst_hready_resp", {31'h0, HREADY_RESP}, 32'h1);
      check("rst_hrdata", HRDATA, 32'h0);
      RST_N = 1'b1;
      repeat (3) @(negedge CLK);
      check_status("rst_status", 0);
      ahb_read(4'h8, d);
      check("rst_ctrl", d, 32'h2);
      check_data("rst_data_empty");
      ahb_read(4'hC, d);
      check("clr_reads_zero", d, 32'h0);

      // Single LSB-first byte.
      ahb_write(4'h8, 32'h3);
      ss_low();
      send_bits(8'hA5, 1'b1, 8);
      ss_high();
      check_status("a5_status", 0);
      check_data("a5_data");
      check_status("a5_status_after", 0);

      // MSB-first back-to-back bytes under one SS.
      ahb_write(4'h8, 32'h1);
      ahb_read(4'h8, d);
      check("ctrl_msb", d, 32'h1);
      ss_low();
      send_bits(8'h3C, 1'b0, 8);
      send_bits(8'hC3, 1'b0, 8);
      ss_high();
      check_data("b2b_first");
      check_data("b2b_second");
      check_data("b2b_empty");

      // Overflow: 5 bytes into a depth-4 FIFO.
      ahb_write(4'h8, 32'h3);
      ss_low();
      for (int i = 1; i <= 5; i++) send_bits(8'(i), 1'b1, 8);
      ss_high();
      check_status("ovr_status", 0);
      for (int i = 0; i < DEPTH; i++) check_data("ovr_drain");
      check_status("ovr_sticky", 0);
      ahb_write(4'hC, 32'h4);
      exp_ovr = 1'b0;
      check_status("ovr_cleared", 0);

      // Abort after 5 bits, then a full byte.
      ss_low();
      send_bits(8'h5A, 1'b1, 5);
      check_status("abort_bitcnt", 5);
      ss_high();
      ss_low();
      send_bits(8'h81, 1'b1, 8);
      ss_high();
      check_data("abort_then_81");
      check_status("abort_status", 0);

      // Randomized frames with random bit order.
      for (int it = 0; it < 5; it++) begin
         lsb = 1'($urandom_range(0, 1));
         ahb_write(4'h8, {30'h0, lsb, 1'b1});
         n = $urandom_range(1, DEPTH);
         ss_low();
         for (int k = 0; k < n; k++) send_bits(8'($urandom), lsb, 8);
         ss_high();
         check_status("rnd_status", 0);
         for (int k = 0; k < n; k++) check_data("rnd_data");
         check_status("rnd_empty", 0);
      end

      // FIFO full, 8th SCLK edge coincides with a DATA pop.
      ahb_write(4'h8, 32'h3);
      ss_low();
      for (int k = 0; k < DEPTH; k++) send_bits(8'($urandom), 1'b1, 8);
      nb = 8'($urandom);
      for (int i = 0; i < 7; i++) spi_bit(nb[i]);
      @(negedge CLK); MOSI = nb[7];
      repeat (4) @(negedge CLK);
      SCLK = 1'b1;
      repeat (2) @(negedge CLK);
      HSEL = 1'b1; HTRANS = 2'b10; HADDR = 4'h0; HWRITE = 1'b0;
      @(negedge CLK);
      HSEL = 1'b0; HTRANS = 2'b00;
      #1 d = HRDATA;
      check("coinc_pop", d, {24'h0, exp_q.pop_front()});
      exp_q.push_back(nb);
      repeat (3) @(negedge CLK);
      SCLK = 1'b0;
      ss_high();
      check_status("coinc_status", 0);
      for (int k = 0; k < DEPTH; k++) check_data("coinc_drain");
      check_data("coinc_empty");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
